// File: rtl/mem_arbiter.sv
// Shares one synchronous-read memory port between instruction fetch and load/store, one access at a time.
// Latency MEM_LATENCY+1 from grant to valid pulse; requesters hold req until valid. Optional MEM_ARB_RR_EN.
module mem_arbiter #(
    parameter int ADDR_WIDTH  = 64,
    parameter int DATA_WIDTH  = 64,
    parameter int MEM_LATENCY = 2
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    if_req,
    input  logic [ADDR_WIDTH-1:0]   if_addr,
    output logic [DATA_WIDTH-1:0]   if_rdata,
    output logic                    if_valid,
    input  logic                    d_req,
    input  logic                    d_we,
    input  logic [ADDR_WIDTH-1:0]   d_addr,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    input  logic [DATA_WIDTH/8-1:0] d_wmask,
    output logic [DATA_WIDTH-1:0]   d_rdata,
    output logic                    d_valid,
    output logic                    mem_en,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wmask,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic                    busy
);
    localparam int MW = DATA_WIDTH / 8;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  owner_q, owner_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [MW-1:0]         wmask_q, wmask_d;
    logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
    logic                  sel_data;

    // owner encoding: 1 = data port, 0 = fetch port
`ifdef MEM_ARB_RR_EN
    logic last_q, last_d;

    assign sel_data = (if_req && d_req) ? ~last_q : d_req;
    assign last_d   = (state_q == IDLE && (if_req || d_req)) ? sel_data : last_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) last_q <= 1'b1;
        else       last_q <= last_d;
    end
`else
    assign sel_data = d_req;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        owner_d    = owner_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wmask_d    = wmask_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        case (state_q)
            IDLE: begin
                if (if_req || d_req) begin
                    owner_d = sel_data;
                    cnt_d   = 4'(MEM_LATENCY - 1);
                    state_d = BUSY;
                    if (sel_data) begin
                        we_d    = d_we;
                        addr_d  = d_addr;
                        wdata_d = d_wdata;
                        wmask_d = d_wmask;
                    end else begin
                        we_d    = 1'b0;
                        addr_d  = if_addr;
                        wdata_d = '0;
                        wmask_d = '0;
                    end
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    if (!we_q) begin
                        if (owner_q) d_rdata_d  = mem_rdata;
                        else         if_rdata_d = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            owner_q    <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wmask_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wmask_q    <= wmask_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    // payload outputs hold their last values; only the strobes are gated by state
    assign mem_en    = (state_q == BUSY);
    assign mem_we    = (state_q == BUSY) && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_wmask = wmask_q;
    assign if_valid  = (state_q == RESP) && !owner_q;
    assign d_valid   = (state_q == RESP) && owner_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed test-plan steps followed by random traffic, checked every cycle
// against a transaction-level timing and memory model.
module tb_mem_arbiter;
    localparam int AW  = 64;
    localparam int DW  = 64;
    localparam int MW  = DW / 8;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          rstn;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_valid;
    logic          d_req, d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [MW-1:0] d_wmask;
    logic [DW-1:0] d_rdata;
    logic          d_valid;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [MW-1:0] mem_wmask;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(LAT)) dut (
        .clk(clk), .rstn(rstn),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wmask(d_wmask),
        .d_rdata(d_rdata), .d_valid(d_valid),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_rdata(mem_rdata), .busy(busy)
    );

    function automatic logic [63:0] merge(logic [63:0] old, logic [63:0] wd, logic [7:0] m);
        logic [63:0] r;
        r = old;
        for (int i = 0; i < 8; i++) if (m[i]) r[8*i +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    // synchronous-read memory attached to the DUT
    logic [DW-1:0] mem [0:2047];
    always @(posedge clk) begin
        if (mem_en) begin
            mem_rdata <= mem[mem_addr[13:3]];
            if (mem_we) mem[mem_addr[13:3]] <= merge(mem[mem_addr[13:3]], mem_wdata, mem_wmask);
        end
    end

    // reference model state
    logic [DW-1:0] shadow [0:2047];
    int            cyc = 0;
    int            grant_at;
    bit            m_own;
    bit            m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [MW-1:0] m_wmask;
    logic [DW-1:0] m_rd, e_if_rdata, e_d_rdata;
    bit            m_last_data;
    int            total = 0;
    int            bad = 0;
    int            ifv, dv, lat;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk1(string tag, logic obs, logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        grant_at    = -1000;
        m_own       = 1'b0;
        m_we        = 1'b0;
        m_addr      = '0;
        m_wdata     = '0;
        m_wmask     = '0;
        m_rd        = '0;
        e_if_rdata  = '0;
        e_d_rdata   = '0;
        m_last_data = 1'b1;
    endtask

    // one clock: update the model from the inputs seen at the edge, then check all outputs
    task automatic step();
        bit ir, dr, pick_d;
        int d;
        @(posedge clk);
        cyc++;
        ir = if_req;
        dr = d_req;
        if (!rstn) begin
            model_reset();
        end else begin
            if (cyc - grant_at == LAT && !m_we) begin
                if (m_own) e_d_rdata = m_rd;
                else       e_if_rdata = m_rd;
            end
            if (cyc - grant_at >= LAT + 2 && (ir || dr)) begin
`ifdef MEM_ARB_RR_EN
                pick_d = (ir && dr) ? !m_last_data : dr;
`else
                pick_d = dr;
`endif
                m_last_data = pick_d;
                m_own       = pick_d;
                grant_at    = cyc;
                m_we        = pick_d ? d_we : 1'b0;
                m_addr      = pick_d ? d_addr : if_addr;
                m_wdata     = pick_d ? d_wdata : '0;
                m_wmask     = pick_d ? d_wmask : '0;
                if (m_we) shadow[m_addr[13:3]] = merge(shadow[m_addr[13:3]], m_wdata, m_wmask);
                else      m_rd = shadow[m_addr[13:3]];
            end
        end
        @(negedge clk);
        d = cyc - grant_at;
        chk1("busy", busy, d <= LAT);
        chk1("mem_en", mem_en, d < LAT);
        chk1("mem_we", mem_we, d < LAT && m_we);
        chk1("if_valid", if_valid, d == LAT && !m_own);
        chk1("d_valid", d_valid, d == LAT && m_own);
        chk("if_rdata", if_rdata, e_if_rdata);
        chk("d_rdata", d_rdata, e_d_rdata);
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_wdata", mem_wdata, m_wdata);
        chk("mem_wmask", 64'(mem_wmask), 64'(m_wmask));
        if (if_valid) ifv = cyc;
        if (d_valid)  dv  = cyc;
    endtask

    task automatic wait_resp(bit port_d, output int n_out);
        n_out = -1;
        for (int n = 1; n <= 30; n++) begin
            step();
            if (port_d ? d_valid : if_valid) begin
                n_out = n;
                break;
            end
        end
        if (port_d) d_req = 1'b0;
        else        if_req = 1'b0;
        if (n_out < 0) begin
            total++;
            bad++;
            $error("FAIL timeout port_d=%0b observed=no_valid expected=valid", port_d);
        end
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) begin
            mem[i]    = '0;
            shadow[i] = '0;
        end
        mem[11'h200]    = 64'hDEADBEEF_00000013;
        shadow[11'h200] = 64'hDEADBEEF_00000013;
        rstn = 1'b0; if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_wmask = '0;
        ifv = -1; dv = -1;
        model_reset();

        // reset then idle
        repeat (3) step();
        rstn = 1'b1;
        repeat (10) step();

        // single fetch
        if_addr = 64'h1000; if_req = 1'b1;
        wait_resp(1'b0, lat);
        chk("fetch_lat", 64'(lat), 64'(LAT + 1));
        chk("fetch_data", if_rdata, 64'hDEADBEEF_00000013);
        step();

        // store then load
        d_addr = 64'h2008; d_we = 1'b1; d_wdata = 64'h11223344_55667788; d_wmask = 8'h0F; d_req = 1'b1;
        wait_resp(1'b1, lat);
        chk("store_lat", 64'(lat), 64'(LAT + 1));
        chk("store_rdata_hold", d_rdata, 64'h0);
        step();
        d_we = 1'b0; d_req = 1'b1;
        wait_resp(1'b1, lat);
        chk("load_data", d_rdata, 64'h00000000_55667788);
        step();

        // simultaneous requests
        ifv = -1; dv = -1;
        if_addr = 64'h1000; if_req = 1'b1; d_req = 1'b1;
        for (int n = 0; n < 40 && (if_req || d_req); n++) begin
            step();
            if (if_valid) if_req = 1'b0;
            if (d_valid)  d_req = 1'b0;
        end
`ifdef MEM_ARB_RR_EN
        chk("conflict_gap", 64'(dv - ifv), 64'(LAT + 2));
`else
        chk("conflict_gap", 64'(ifv - dv), 64'(LAT + 2));
`endif
        step();

        // payload change while busy
        d_addr = 64'h3000; d_we = 1'b0; d_req = 1'b1;
        step();
        d_addr = 64'h4000;
        step();
        chk("busy_addr_hold", mem_addr, 64'h3000);
        wait_resp(1'b1, lat);
        chk("busy_change_lat", 64'(lat), 64'(LAT - 1));
        step();

        // reset in the middle of a load
        d_addr = 64'h2008; d_req = 1'b1;
        step();
        step();
        rstn = 1'b0;
        step();
        step();
        rstn = 1'b1;
        wait_resp(1'b1, lat);
        chk("post_reset_lat", 64'(lat), 64'(LAT + 1));
        chk("post_reset_data", d_rdata, 64'h00000000_55667788);
        step();

        // random traffic
        for (int n = 0; n < 600; n++) begin
            step();
            if (if_valid) if_req = 1'b0;
            else if (!if_req && $urandom_range(0, 3) == 0) begin
                if_addr = 64'($urandom_range(0, 31)) << 3;
                if_req  = 1'b1;
            end
            if (d_valid) d_req = 1'b0;
            else if (!d_req && $urandom_range(0, 3) == 0) begin
                d_addr  = 64'($urandom_range(0, 31)) << 3;
                d_we    = 1'($urandom_range(0, 1));
                d_wdata = {$urandom, $urandom};
                d_wmask = 8'($urandom_range(0, 255));
                d_req   = 1'b1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
